// File: rtl/key_led_ctrl.sv
// Push-button debouncer and LED pattern sequencer: keys select a walk direction, a free-running counter paces the LEDs.
// Latency: key_level/key_rise DEBOUNCE_CNT+2 cycles after a stable raw level, mode +1 cycle, led_out +1 more cycle.
// Backpressure: none; keys are sampled every cycle and all outputs are free-running registers.
module key_led_ctrl #(
  parameter int NUM_KEYS     = 2,
  parameter int NUM_LEDS     = 4,
  parameter int DEBOUNCE_CNT = 8192,
  parameter int STEP_W       = 26
) (
  input  logic                              clk_50m,
  input  logic                              rst_n,
  input  logic [NUM_KEYS-1:0]               key,
  output logic [NUM_KEYS-1:0]               key_level,
  output logic [NUM_KEYS-1:0]               key_rise,
  output logic [$clog2(NUM_KEYS+1)-1:0]     mode,
  output logic [NUM_LEDS-1:0]               led_out
);

  localparam int MODE_W = $clog2(NUM_KEYS+1);
  localparam int POS_W  = $clog2(NUM_LEDS);
  localparam int CNT_W  = $clog2(DEBOUNCE_CNT);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CNT-1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [POS_W-1:0]  POS_LAST = POS_W'(NUM_LEDS-1);
  localparam logic [POS_W-1:0]  POS_ONE  = POS_W'(1);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

  // Synchronizer stages; raw keys touch nothing but key_meta.
  logic [NUM_KEYS-1:0] key_meta;
  logic [NUM_KEYS-1:0] key_sync;

  // Debounce state, one counter per key.
  logic [CNT_W-1:0]    db_cnt     [NUM_KEYS];
  logic [CNT_W-1:0]    db_cnt_nxt [NUM_KEYS];
  logic [NUM_KEYS-1:0] level_nxt;
  logic [NUM_KEYS-1:0] rise_nxt;

  // Pattern sequencing state.
  logic [STEP_W-1:0]   step_cnt;
  logic                strobe;
  logic [POS_W-1:0]    pos;
  logic [POS_W-1:0]    pos_nxt;
  logic [POS_W-1:0]    pos_rev;
  logic [MODE_W-1:0]   mode_nxt;
  logic [NUM_LEDS-1:0] led_nxt;

  // Two-flop synchronizer on every key bit.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= '0;
      key_sync <= '0;
    end else begin
      key_meta <= key;
      key_sync <= key_meta;
    end
  end

  // Per-key debounce: a level differing from the accepted one must persist for
  // DEBOUNCE_CNT consecutive cycles; any return to the accepted level restarts it.
  always_comb begin
    level_nxt = key_level;
    rise_nxt  = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      db_cnt_nxt[i] = db_cnt[i];
      if (key_sync[i] == key_level[i]) begin
        db_cnt_nxt[i] = '0;
      end else if (db_cnt[i] == CNT_LAST) begin
        level_nxt[i]  = key_sync[i];
        rise_nxt[i]   = key_sync[i];
        db_cnt_nxt[i] = '0;
      end else begin
        db_cnt_nxt[i] = db_cnt[i] + CNT_ONE;
      end
    end
  end

  // Debounce registers; key_rise is high only for the acceptance cycle of a press.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        db_cnt[i] <= '0;
      end
      key_level <= '0;
      key_rise  <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        db_cnt[i] <= db_cnt_nxt[i];
      end
      key_level <= level_nxt;
      key_rise  <= rise_nxt;
    end
  end

  // Mode select: lowest pulsing key index wins; no pulse keeps the mode.
  // Mode 0 is only ever produced by reset since every pulse maps to i+1.
  always_comb begin
    mode_nxt = mode;
    for (int i = NUM_KEYS-1; i >= 0; i--) begin
      if (key_rise[i]) begin
        mode_nxt = MODE_W'(i+1);
      end
    end
  end

  assign strobe = &step_cnt;

  // Walk position: restart at 0 on any key press, otherwise step on the strobe
  // with an explicit wrap so non-power-of-two LED counts stay in range.
  always_comb begin
    pos_nxt = pos;
    if (|key_rise) begin
      pos_nxt = '0;
    end else if (strobe) begin
      pos_nxt = (pos == POS_LAST) ? '0 : pos + POS_ONE;
    end
  end

  assign pos_rev = POS_LAST - pos;

  // LED pattern: common blink in mode 0, upward walk in odd modes, downward in even.
  always_comb begin
    led_nxt = '0;
    if (mode == '0) begin
      led_nxt = {NUM_LEDS{step_cnt[STEP_W-1]}};
    end else if (mode[0]) begin
      led_nxt[pos] = 1'b1;
    end else begin
      led_nxt[pos_rev] = 1'b1;
    end
  end

  // Sequencer registers; step_cnt free-runs and is cleared only by reset.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
      mode     <= '0;
      pos      <= '0;
      led_out  <= '0;
    end else begin
      step_cnt <= step_cnt + STEP_ONE;
      mode     <= mode_nxt;
      pos      <= pos_nxt;
      led_out  <= led_nxt;
    end
  end

endmodule

// File: tb/tb_key_led_ctrl.sv
// Bench for key_led_ctrl: directed scenarios with literal expectations plus random key traffic.
// Outputs are compared on every falling edge against a window-based behavioural model.
// No flow control involved; the bench drives keys and reset directly.
module tb_key_led_ctrl;

  localparam int NK = 3;
  localparam int NL = 4;
  localparam int D  = 16;
  localparam int SW = 4;

  logic          clk_50m = 1'b0;
  logic          rst_n   = 1'b0;
  logic [NK-1:0] key     = '0;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_rise;
  logic [1:0]    mode;
  logic [NL-1:0] led_out;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  key_led_ctrl #(
    .NUM_KEYS(NK), .NUM_LEDS(NL), .DEBOUNCE_CNT(D), .STEP_W(SW)
  ) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .key(key),
    .key_level(key_level), .key_rise(key_rise), .mode(mode), .led_out(led_out)
  );

  always #5 clk_50m = ~clk_50m;

  // Behavioural model. hist[j] is the raw key seen at the edge j edges ago;
  // the debouncer acts at each edge on the raw value from two edges earlier,
  // and accepts a flip when its last D such samples all oppose the current level.
  logic [NK-1:0] hist [0:D+1];
  logic [NK-1:0] m_lvl  = '0;
  logic [NK-1:0] m_rise = '0;
  int            m_mode = 0;
  int            m_pos  = 0;
  int            m_step = 0;
  logic [NL-1:0] m_led  = '0;
  logic [NK-1:0] acc;
  logic [NK-1:0] new_lvl;
  int            new_mode;
  int            new_pos;
  bit            all_opp;

  initial begin
    for (int j = 0; j <= D+1; j++) hist[j] = '0;
  end

  function automatic logic [NL-1:0] led_of(input int md, input int p, input int st);
    logic [NL-1:0] r;
    if (md == 0)          r = (st >= (1 << (SW-1))) ? '1 : '0;
    else if (md % 2 == 1) r = NL'(1) << p;
    else                  r = NL'(1) << (NL-1-p);
    return r;
  endfunction

  always @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j <= D+1; j++) hist[j] = '0;
      m_lvl = '0; m_rise = '0; m_mode = 0; m_pos = 0; m_step = 0; m_led = '0;
    end else begin
      for (int j = D+1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = key;
      acc = '0;
      for (int i = 0; i < NK; i++) begin
        all_opp = 1'b1;
        for (int j = 2; j <= D+1; j++) if (hist[j][i] == m_lvl[i]) all_opp = 1'b0;
        acc[i] = all_opp;
      end
      new_lvl  = m_lvl ^ acc;
      new_mode = m_mode;
      for (int i = NK-1; i >= 0; i--) if (m_rise[i]) new_mode = i + 1;
      new_pos = m_pos;
      if (m_step == (1 << SW) - 1) new_pos = (m_pos + 1) % NL;
      if (m_rise != 0) new_pos = 0;
      m_led  = led_of(m_mode, m_pos, m_step);
      m_rise = acc & new_lvl;
      m_lvl  = new_lvl;
      m_mode = new_mode;
      m_pos  = new_pos;
      m_step = (m_step + 1) % (1 << SW);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk_50m) begin
    if (chk_en) begin
      check("model_key_level", 32'(key_level), 32'(m_lvl));
      check("model_key_rise",  32'(key_rise),  32'(m_rise));
      check("model_mode",      32'(mode),      32'(m_mode));
      check("model_led_out",   32'(led_out),   32'(m_led));
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk_50m);
  endtask

  initial begin
    rst_n = 1'b0;
    key   = '0;
    wait_n(3);
    chk_en = 1'b1;
    check("reset_level", 32'(key_level), 32'h0);
    check("reset_rise",  32'(key_rise),  32'h0);
    check("reset_mode",  32'(mode),      32'h0);
    check("reset_led",   32'(led_out),   32'h0);

    // Clean press of key 0 from edge 0, then the walk-up wrap.
    key = 3'b001; rst_n = 1'b1;
    wait_n(8);  check("blink_low_e8",   32'(led_out),   32'h0);
    wait_n(1);  check("blink_high_e9",  32'(led_out),   32'hF);
    wait_n(8);  check("press_lvl_e17",  32'(key_level), 32'h0);
    wait_n(1);  check("press_lvl_e18",  32'(key_level), 32'h1);
                check("press_rise_e18", 32'(key_rise),  32'h1);
    wait_n(1);  check("press_rise_e19", 32'(key_rise),  32'h0);
                check("press_mode_e19", 32'(mode),      32'h1);
    wait_n(1);  check("walk_e20",       32'(led_out),   32'h1);
    wait_n(12); check("walk_e32",       32'(led_out),   32'h1);
    wait_n(1);  check("walk_e33",       32'(led_out),   32'h2);
    wait_n(16); check("walk_e49",       32'(led_out),   32'h4);
    wait_n(16); check("walk_e65",       32'(led_out),   32'h8);
    wait_n(16); check("walk_e81",       32'(led_out),   32'h1);

    // Glitch of 15 cycles on key 1 must vanish.
    key = 3'b011; wait_n(15);
    key = 3'b001; wait_n(30);
    check("glitch_level", 32'(key_level), 32'h1);
    check("glitch_mode",  32'(mode),      32'h1);

    // Keys 1 and 2 pressed together: index 1 wins.
    key = 3'b111;
    wait_n(18); check("simul_rise", 32'(key_rise), 32'h6);
    wait_n(1);  check("simul_mode", 32'(mode),     32'h2);
    wait_n(1);  check("simul_led",  32'(led_out),  32'h8);
    wait_n(20);

    // Release of key 2: falls after D+2 edges, no pulse, mode kept.
    key = 3'b011;
    wait_n(17); check("rel_lvl_e17", 32'(key_level), 32'h7);
    wait_n(1);  check("rel_lvl_e18", 32'(key_level), 32'h3);
                check("rel_rise",    32'(key_rise),  32'h0);
                check("rel_mode",    32'(mode),      32'h2);

    // Reset in the middle of a debounce with the key still held.
    key = 3'b000; wait_n(25);
    key = 3'b100; wait_n(10);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_level", 32'(key_level), 32'h0);
    check("mid_rst_rise",  32'(key_rise),  32'h0);
    check("mid_rst_mode",  32'(mode),      32'h0);
    check("mid_rst_led",   32'(led_out),   32'h0);
    wait_n(2);
    rst_n = 1'b1;
    wait_n(17); check("rst_rise_e17", 32'(key_rise), 32'h0);
    wait_n(1);  check("rst_rise_e18", 32'(key_rise), 32'h4);
                check("rst_lvl_e18",  32'(key_level), 32'h4);

    // Random key traffic with occasional resets, checked by the model.
    for (int s = 0; s < 150; s++) begin
      key = NK'($urandom_range(0, (1 << NK) - 1));
      if ($urandom_range(0, 2) == 0) wait_n($urandom_range(1, D));
      else                           wait_n($urandom_range(D, 3*D));
      if ($urandom_range(0, 29) == 0) begin
        #2 rst_n = 1'b0;
        wait_n(2);
        rst_n = 1'b1;
      end
    end

    wait_n(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/key_led_ctrl.md
KEY_LED_CTRL -- requirements
Module: key_led_ctrl

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 2: number of push-button inputs, range 1..8.
REQ-002 SHALL have parameter NUM_LEDS, default 4: number of LED outputs, range 2..16.
REQ-003 SHALL have parameter DEBOUNCE_CNT, default 8192: cycles a changed key level must persist before acceptance, minimum 2.
REQ-004 SHALL have parameter STEP_W, default 26: width of the free-running pattern counter, minimum 2.
REQ-005 SHALL derive localparam MODE_W = $clog2(NUM_KEYS+1) and POS_W = $clog2(NUM_LEDS).
REQ-006 SHALL use clock and reset exactly as decided:
- clk_50m  input  1: sole clock, all state on its rising edge.
- rst_n  input  1: asynchronous, active-low reset.
REQ-007 SHALL have these ports:
- key  input  NUM_KEYS: raw asynchronous buttons, active-high.
- key_level  output  NUM_KEYS: debounced key level.
- key_rise  output  NUM_KEYS: one-cycle pulse on each debounced 0->1 transition.
- mode  output  MODE_W: current LED mode.
- led_out  output  NUM_LEDS: LED drive, active-high.

Function
REQ-010 SHALL pass each key bit through a 2-flop synchronizer (key_sync) before any other use.
REQ-011 SHALL give each key an independent debounce counter with the following per-cycle rule:
- key_sync == key_level: counter <= 0.
- Else if counter == DEBOUNCE_CNT-1: key_level <= key_sync and counter <= 0.
- Else: counter + 1.
REQ-012 SHALL assert key_rise[i] (registered) for exactly the one cycle in which key_level[i] first reads 1 after a 0->1 acceptance; a 1->0 acceptance SHALL produce no pulse.
REQ-013 SHALL give this latency: raw key held high from edge 0 gives key_level and key_rise high after edge DEBOUNCE_CNT+2.
REQ-014 SHALL discard any raw glitch shorter than DEBOUNCE_CNT cycles, because the counter clears on the first cycle key_sync equals key_level again.
REQ-015 SHALL update mode on the edge after a key_rise cycle: mode <= i+1, where i is the lowest index with key_rise[i]=1 (lowest index wins on simultaneous pulses); with no pulse, mode holds.
REQ-016 SHALL keep mode 0 (reset value) unreachable except through reset.
REQ-017 SHALL run a STEP_W-bit counter (step_cnt) that increments every cycle and wraps from all-ones to 0; step_cnt is never cleared except by reset.
REQ-018 SHALL define step strobe = (step_cnt == all-ones).
REQ-019 SHALL maintain a position register pos (POS_W bits) with the following rules:
- On strobe, pos advances by 1 and wraps NUM_LEDS-1 -> 0.
- Any key_rise pulse forces pos <= 0 on the same edge that updates mode, overriding a coincident strobe.
REQ-020 SHALL register led_out from mode, pos and step_cnt, one cycle after they change:
- mode 0: all bits = step_cnt[STEP_W-1] (common blink).
- mode odd: one-hot, bit pos set (walk up).
- mode even, nonzero: one-hot, bit NUM_LEDS-1-pos set (walk down).
REQ-021 SHALL always produce a one-hot led_out in a walk mode, including non-power-of-two NUM_LEDS; pos never exceeds NUM_LEDS-1.
REQ-022 SHALL use no combinational path from key to any output.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force key_sync, key_level, key_rise, all debounce counters, mode, step_cnt, pos and led_out to 0.
REQ-031 SHALL discard any debounce in progress when reset asserts; after release, a still-held key requires a full DEBOUNCE_CNT+2 cycles.
REQ-032 SHALL reach the first output change after reset release only through synchronous operation; rst_n deassertion is synchronized externally.

Verification (NUM_KEYS=3, NUM_LEDS=4, DEBOUNCE_CNT=16, STEP_W=4)
REQ-040 SHALL cover clean press: key=3'b001 held from edge 0 -> key_level[0]=1 and key_rise=3'b001 for one cycle after edge 18; mode=1 after edge 19; led_out=4'b0001 after edge 20.
REQ-041 SHALL cover glitch: key[1] high for 15 cycles then low -> key_level, key_rise and mode unchanged.
REQ-042 SHALL cover simultaneous press: key 3'b110 rising together -> single key_rise cycle with 3'b110, mode=2 (index 1 wins), led_out=4'b1000, then 4'b0100 after the next strobe.
REQ-043 SHALL cover walk wrap: mode=1 over 64 cycles -> led_out sequence 0001,0010,0100,1000,0001, changing every 16 cycles.
REQ-044 SHALL cover release: held key[2] released -> key_level[2] falls DEBOUNCE_CNT+2 edges later, with no key_rise and mode unchanged.
REQ-045 SHALL cover reset mid-debounce: rst_n low at cycle 10 of a press, key still held -> all outputs 0; key_rise fires 18 edges after rst_n high.
